// File: rtl/fibo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fibo_arbiter
//  Purpose  : Round-robin sharing of one fibo engine between N requesters,
//             with a watchdog bounding the wait for the engine result.
//  Revision : 1.0  initial release
// ============================================================================
module fibo_arbiter #(
    parameter int N   = 4,
    parameter int IW  = 5,
    parameter int FW  = 20,
    parameter int TMO = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*IW-1:0] arg,
    output logic [N-1:0]    resp_valid,
    output logic [FW-1:0]   resp_data,
    output logic            resp_err,
    output logic            busy,
    output logic            eng_start,
    output logic [IW-1:0]   eng_i,
    input  logic            eng_ready,
    input  logic            eng_done_tick,
    input  logic [FW-1:0]   eng_f
);

    localparam int IXW = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = $clog2(TMO);

    localparam logic [1:0]     c_IDLE     = 2'd0;
    localparam logic [1:0]     c_ISSUE    = 2'd1;
    localparam logic [1:0]     c_WAIT     = 2'd2;
    localparam logic [1:0]     c_RESP     = 2'd3;
    localparam logic [WDW-1:0] c_WD_LAST  = WDW'(TMO - 1);
    localparam logic [IXW-1:0] c_LAST_IDX = IXW'(N - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [IXW-1:0]  r_rr_ptr;
    logic [IXW-1:0]  r_cur_idx;
    logic [IW-1:0]   r_cur_arg;
    logic [FW-1:0]   r_result;
    logic            r_err;
    logic [WDW-1:0]  r_wdog;

    logic [2*N-1:0]  w_dbl;
    logic [N-1:0]    w_rot;
    logic            w_found;
    logic [IXW-1:0]  w_pick;
    logic [IXW:0]    w_sum;
    logic [IW-1:0]   w_pick_arg;
    logic            w_expire;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_dbl    = {req, req} >> r_rr_ptr;
    assign w_rot    = w_dbl[N-1:0];
    assign w_expire = (r_wdog == c_WD_LAST);

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_sum   = '0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (IXW + 1)'(j);
                if (w_sum >= (IXW + 1)'(N)) begin
                    w_sum = w_sum - (IXW + 1)'(N);
                end
                w_pick = w_sum[IXW-1:0];
            end
        end
    end

    always_comb begin
        w_pick_arg = '0;
        for (int k = 0; k < N; k++) begin
            if (w_pick == IXW'(k)) begin
                w_pick_arg = arg[k*IW +: IW];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_found && eng_ready) w_next_state = c_ISSUE;
            c_ISSUE: w_next_state = c_WAIT;
            c_WAIT:  if (eng_done_tick || w_expire) w_next_state = c_RESP;
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Datapath registers; a done_tick in the expiry cycle takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_cur_idx <= '0;
            r_cur_arg <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_wdog    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found && eng_ready) begin
                        r_cur_idx <= w_pick;
                        r_cur_arg <= w_pick_arg;
                    end
                end
                c_ISSUE: begin
                    r_wdog <= '0;
                end
                c_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (eng_done_tick) begin
                        r_result <= eng_f;
                        r_err    <= 1'b0;
                    end else if (w_expire) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                c_RESP: begin
                    r_rr_ptr <= (r_cur_idx == c_LAST_IDX) ? '0 : r_cur_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        resp_err   = 1'b0;
        busy       = (r_state != c_IDLE);
        eng_start  = (r_state == c_ISSUE);
        eng_i      = r_cur_arg;
        if (r_state == c_RESP) begin
            resp_data = r_result;
            resp_err  = r_err;
            for (int k = 0; k < N; k++) begin
                resp_valid[k] = (r_cur_idx == IXW'(k));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fibo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fibo_arbiter
//  Purpose  : Self-checking bench for fibo_arbiter with a behavioural engine
//             stub and a job-level reference model of the arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fibo_arbiter;

    localparam int N   = 4;
    localparam int IW  = 5;
    localparam int FW  = 20;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*IW-1:0] arg = '0;
    logic [N-1:0]    resp_valid;
    logic [FW-1:0]   resp_data;
    logic            resp_err;
    logic            busy;
    logic            eng_start;
    logic [IW-1:0]   eng_i;
    logic            eng_ready;
    logic            eng_done_tick;
    logic [FW-1:0]   eng_f;

    always #5 clk = ~clk;

    fibo_arbiter #(.N(N), .IW(IW), .FW(FW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .arg(arg),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .eng_start(eng_start), .eng_i(eng_i),
        .eng_ready(eng_ready), .eng_done_tick(eng_done_tick), .eng_f(eng_f)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] fib(input int n);
        logic [FW-1:0] a = '0;
        logic [FW-1:0] b = FW'(1);
        logic [FW-1:0] s;
        for (int i = 0; i < n; i++) begin
            s = a + b;
            a = b;
            b = s;
        end
        return a;
    endfunction

    // Engine stub: 0 = healthy fibo timing, 1 = never signals done,
    // 2 = done_tick lands exactly in the watchdog expiry cycle.
    int            eng_mode = 0;
    logic [FW-1:0] stub_val = '0;
    logic          e_busy;
    int            e_cnt;
    logic [FW-1:0] e_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_busy <= 1'b0;
            e_cnt  <= 0;
            e_val  <= '0;
        end else if (!e_busy) begin
            if (eng_start) begin
                e_busy <= 1'b1;
                case (eng_mode)
                    1: begin e_cnt <= 1;       e_val <= '0;       end
                    2: begin e_cnt <= TMO - 1; e_val <= stub_val; end
                    default: begin
                        e_cnt <= (eng_i == '0) ? 1 : int'(eng_i);
                        e_val <= fib(int'(eng_i));
                    end
                endcase
            end
        end else if (e_cnt == 0) begin
            e_busy <= 1'b0;
        end else begin
            e_cnt <= e_cnt - 1;
        end
    end

    assign eng_ready     = !e_busy;
    assign eng_done_tick = e_busy && (e_cnt == 0) && (eng_mode != 1);
    assign eng_f         = eng_done_tick ? e_val : ~e_val;

    // Reference model: one job in flight, response time predicted at grant.
    bit            m_active = 1'b0;
    int            m_g = 0, m_R = 0, m_idx = 0, m_rr = 0, m_free = 0;
    logic [FW-1:0] m_data = '0;
    bit            m_err = 1'b0;
    logic [IW-1:0] m_eng_i = '0;

    bit            want[N];
    bit            dropped[N];
    bit            granted[N];
    bit            rearm[N];
    logic [IW-1:0] rarg[N];
    bit            rand_en = 1'b0;

    typedef struct {int idx; int data; bit err; int cyc;} resp_t;
    resp_t log_q[$];
    int    grant_idx_q[$];
    int    grant_cyc_q[$];

    task automatic model_clear();
        m_active = 1'b0; m_rr = 0; m_free = 0; m_eng_i = '0;
        for (int k = 0; k < N; k++) begin
            want[k] = 1'b0; dropped[k] = 1'b0; granted[k] = 1'b0; rearm[k] = 1'b0;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req[k]           = want[k] && !dropped[k];
            arg[k*IW +: IW]  = rarg[k];
        end
    endtask

    task automatic model_grant();
        int  k;
        int  n;
        bit  found;
        found = 1'b0;
        k     = 0;
        if (rst || m_active || t < m_free || req == '0) return;
        for (int j = 0; j < N; j++) begin
            if (!found && req[(m_rr + j) % N]) begin
                found = 1'b1;
                k     = (m_rr + j) % N;
            end
        end
        n        = int'(rarg[k]);
        m_active = 1'b1;
        m_g      = t;
        m_idx    = k;
        m_eng_i  = rarg[k];
        case (eng_mode)
            1:       begin m_R = t + TMO + 2; m_data = '0;       m_err = 1'b1; end
            2:       begin m_R = t + TMO + 2; m_data = stub_val; m_err = 1'b0; end
            default: begin m_R = t + ((n == 0) ? 1 : n) + 3; m_data = fib(n); m_err = 1'b0; end
        endcase
        granted[k] = 1'b1;
        grant_idx_q.push_back(k);
        grant_cyc_q.push_back(t);
    endtask

    task automatic tick();
        logic [N-1:0] erv;
        bit           rv_now;
        int           ridx;
        if (rand_en) begin
            for (int k = 0; k < N; k++) begin
                if (!want[k] && $urandom_range(0, 5) == 0) begin
                    want[k] = 1'b1;
                    rarg[k] = IW'($urandom);
                end else if (granted[k] && !dropped[k] && $urandom_range(0, 9) == 0) begin
                    dropped[k] = 1'b1;
                end
            end
        end
        drive();
        model_grant();
        @(posedge clk);
        #1;
        t++;
        rv_now = m_active && (t == m_R);
        erv    = '0;
        if (rv_now) erv[m_idx] = 1'b1;
        check_eq("resp_valid", 32'(resp_valid), 32'(erv));
        check_eq("resp_data",  32'(resp_data),  rv_now ? 32'(m_data) : 32'd0);
        check_eq("resp_err",   32'(resp_err),   32'(rv_now && m_err));
        check_eq("busy",       32'(busy),       32'(m_active && t > m_g));
        check_eq("eng_start",  32'(eng_start),  32'(m_active && t == m_g + 1));
        check_eq("eng_i",      32'(eng_i),      32'(m_eng_i));
        if (resp_valid != '0) begin
            ridx = 0;
            for (int k = 0; k < N; k++) if (resp_valid[k]) ridx = k;
            log_q.push_back('{idx: ridx, data: int'(resp_data), err: resp_err, cyc: t});
        end
        if (rv_now) begin
            m_active       = 1'b0;
            m_rr           = (m_idx + 1) % N;
            m_free         = t + 1;
            granted[m_idx] = 1'b0;
            dropped[m_idx] = 1'b0;
            want[m_idx]    = rearm[m_idx];
        end
    endtask

    function automatic bit any_want();
        bit a = 1'b0;
        for (int k = 0; k < N; k++) a |= want[k];
        return a;
    endfunction

    task automatic drain(input int budget);
        int b = 0;
        while ((m_active || any_want()) && b < budget) begin
            tick();
            b++;
        end
        check_eq("drain_idle", 32'(m_active || any_want()), 32'd0);
    endtask

    task automatic wait_grants(input int cnt, input int budget);
        int b = 0;
        while (grant_idx_q.size() < cnt && b < budget) begin
            tick();
            b++;
        end
        check_eq("wait_grant", 32'(grant_idx_q.size() >= cnt), 32'd1);
    endtask

    task automatic wait_resps(input int cnt, input int budget);
        int b = 0;
        while (log_q.size() < cnt && b < budget) begin
            tick();
            b++;
        end
        check_eq("wait_resp", 32'(log_q.size() >= cnt), 32'd1);
    endtask

    task automatic clear_logs();
        log_q.delete();
        grant_idx_q.delete();
        grant_cyc_q.delete();
    endtask

    task automatic check_resp(input string tag, input int i, input int idx,
                              input int data, input bit err, input int lat);
        check_eq({tag, "_present"}, 32'(log_q.size() > i), 32'd1);
        if (log_q.size() > i) begin
            check_eq({tag, "_idx"},  32'(log_q[i].idx),  32'(idx));
            check_eq({tag, "_data"}, 32'(log_q[i].data), 32'(data));
            check_eq({tag, "_err"},  32'(log_q[i].err),  32'(err));
            if (grant_cyc_q.size() > i) begin
                check_eq({tag, "_lat"}, 32'(log_q[i].cyc - grant_cyc_q[i]), 32'(lat));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) rarg[k] = '0;
        model_clear();
        tick();
        tick();
        check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("reset_busy",       32'(busy),       32'd0);
        check_eq("reset_eng_start",  32'(eng_start),  32'd0);
        check_eq("reset_eng_i",      32'(eng_i),      32'd0);
        rst = 1'b0;
        tick();

        // Single job, argument 10
        clear_logs();
        want[0] = 1'b1; rarg[0] = 5'd10;
        drain(200);
        check_resp("t1", 0, 0, 55, 1'b0, 13);

        // Four simultaneous requests served in round-robin order
        do_reset();
        clear_logs();
        rarg[0] = 5'd0; rarg[1] = 5'd1; rarg[2] = 5'd2; rarg[3] = 5'd20;
        for (int k = 0; k < N; k++) want[k] = 1'b1;
        drain(400);
        check_resp("t2_0", 0, 0, 0,    1'b0, 4);
        check_resp("t2_1", 1, 1, 1,    1'b0, 4);
        check_resp("t2_2", 2, 2, 1,    1'b0, 5);
        check_resp("t2_3", 3, 3, 6765, 1'b0, 23);

        // Continuous requester 0 must not starve requester 2
        clear_logs();
        rearm[0] = 1'b1; want[0] = 1'b1; rarg[0] = 5'd3;
        wait_grants(1, 50);
        tick();
        tick();
        want[2] = 1'b1; rarg[2] = 5'd4;
        wait_resps(3, 200);
        rearm[0] = 1'b0;
        drain(200);
        check_eq("t3_grant0", 32'(grant_idx_q.size() > 0 ? grant_idx_q[0] : -1), 32'd0);
        check_eq("t3_grant1", 32'(grant_idx_q.size() > 1 ? grant_idx_q[1] : -1), 32'd2);
        check_eq("t3_grant2", 32'(grant_idx_q.size() > 2 ? grant_idx_q[2] : -1), 32'd0);

        // Silent engine: watchdog error, then the next job proceeds
        clear_logs();
        eng_mode = 1;
        want[1] = 1'b1; rarg[1] = 5'd9;
        wait_grants(1, 50);
        repeat (5) tick();
        eng_mode = 0;
        want[3] = 1'b1; rarg[3] = 5'd5;
        drain(300);
        check_resp("t4_err",  0, 1, 0, 1'b1, TMO + 2);
        check_resp("t4_next", 1, 3, 5, 1'b0, 8);

        // Reset during WAIT abandons the job and clears rr_ptr
        clear_logs();
        want[1] = 1'b1; rarg[1] = 5'd1;
        drain(100);
        clear_logs();
        want[2] = 1'b1; rarg[2] = 5'd25;
        wait_grants(1, 50);
        repeat (6) tick();
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("t5_rst_resp_data",  32'(resp_data),  32'd0);
        check_eq("t5_rst_busy",       32'(busy),       32'd0);
        check_eq("t5_rst_eng_start",  32'(eng_start),  32'd0);
        check_eq("t5_rst_eng_i",      32'(eng_i),      32'd0);
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        grant_idx_q.delete();
        grant_cyc_q.delete();
        want[1] = 1'b1; rarg[1] = 5'd4;
        want[2] = 1'b1; rarg[2] = 5'd7;
        drain(200);
        check_eq("t5_resp_count", 32'(log_q.size()), 32'd2);
        check_resp("t5_a", 0, 1, 3,  1'b0, 7);
        check_resp("t5_b", 1, 2, 13, 1'b0, 10);

        // Largest healthy argument and coincident done/expiry
        clear_logs();
        want[3] = 1'b1; rarg[3] = 5'd30;
        drain(200);
        check_resp("t6_big", 0, 3, 832040, 1'b0, 33);
        clear_logs();
        eng_mode = 2;
        stub_val = 20'h5A5A5;
        want[0] = 1'b1; rarg[0] = 5'd2;
        drain(200);
        eng_mode = 0;
        check_resp("t6_tie", 0, 0, 32'h5A5A5, 1'b0, TMO + 2);

        // Randomized traffic against the reference model
        clear_logs();
        rand_en = 1'b1;
        repeat (1500) tick();
        rand_en = 1'b0;
        drain(600);
        check_eq("rand_activity", 32'(log_q.size() > 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
